// File: rtl/wishbone_mem_slave_if.sv
// Wishbone classic-cycle slave-port bundle between the interconnect and the memory responder.
interface wishbone_mem_slave_if;
  logic        i_wbs_we;
  logic        i_wbs_stb;
  logic        i_wbs_cyc;
  logic [3:0]  i_wbs_sel;
  logic [31:0] i_wbs_adr;
  logic [31:0] i_wbs_dat;
  logic [31:0] o_wbs_dat;
  logic        o_wbs_ack;
  logic        o_wbs_int;

  modport master (
    output i_wbs_we, i_wbs_stb, i_wbs_cyc, i_wbs_sel, i_wbs_adr, i_wbs_dat,
    input  o_wbs_dat, o_wbs_ack, o_wbs_int
  );

  modport slave (
    input  i_wbs_we, i_wbs_stb, i_wbs_cyc, i_wbs_sel, i_wbs_adr, i_wbs_dat,
    output o_wbs_dat, o_wbs_ack, o_wbs_int
  );
endinterface

// File: rtl/wishbone_mem_slave.sv
// Wishbone classic-cycle responder over a word-addressed synchronous RAM.
// Reads take one wait state; ack is held until the master drops stb or cyc.
//   state     | meaning
//   S_IDLE    | no ack, request inputs sampled
//   S_RD_WAIT | RAM read issued, data captured on exit
//   S_ACK     | ack high while stb & cyc persist
module wishbone_mem_slave #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input logic                clk,
  input logic                rst,
  wishbone_mem_slave_if.slave wbs
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_ACK     = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_rd_word;
  logic                  r_rd_oor;
  logic [31:0]           r_dat;
  logic                  r_ack;
  logic                  r_int;

  logic                  w_req;
  logic                  w_in_range;
  logic                  w_wr_ok;
  logic                  w_rd_done;
  logic [ADDR_WIDTH-1:0] w_idx;

  assign w_req      = (r_state == S_IDLE) && wbs.i_wbs_stb && wbs.i_wbs_cyc;
  assign w_in_range = (wbs.i_wbs_adr < 32'(DEPTH));
  assign w_idx      = wbs.i_wbs_adr[ADDR_WIDTH-1:0];
  assign w_wr_ok    = w_req && wbs.i_wbs_we && w_in_range;
  assign w_rd_done  = (r_state == S_RD_WAIT) && wbs.i_wbs_cyc;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) w_state_nxt = wbs.i_wbs_we ? S_ACK : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_state_nxt = wbs.i_wbs_cyc ? S_ACK : S_IDLE;
      end
      S_ACK: begin
        if (!(wbs.i_wbs_stb && wbs.i_wbs_cyc)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_ack    <= 1'b0;
      r_dat    <= 32'h0;
      r_int    <= 1'b0;
      r_rd_oor <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (w_state_nxt == S_ACK);
      if (w_req) r_rd_oor <= !w_in_range;
      if (w_rd_done) r_dat <= r_rd_oor ? 32'h0 : r_rd_word;
      // set has priority over clear
      if (w_req && !w_in_range) r_int <= 1'b1;
      else if (w_wr_ok)         r_int <= 1'b0;
    end
  end

  // Memory contents survive reset; a write sampled while rst is low is not committed.
  always_ff @(posedge clk) begin
    if (rst && w_wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs.i_wbs_sel[b]) r_mem[w_idx][8*b +: 8] <= wbs.i_wbs_dat[8*b +: 8];
      end
    end
    if (w_req && !wbs.i_wbs_we) r_rd_word <= r_mem[w_idx];
  end

  assign wbs.o_wbs_dat = r_dat;
  assign wbs.o_wbs_ack = r_ack;
  assign wbs.o_wbs_int = r_int;

endmodule

// File: doc/wishbone_mem_slave.md
# wishbone_mem_slave

Wishbone classic-cycle responder backed by an on-chip word-addressed memory. It sits on one slave port of the memory interconnect. It accepts single read/write cycles with byte-lane selects, inserts one wait state on reads for the synchronous RAM, and holds ack until the master releases strobe. Out-of-range accesses complete normally and raise a sticky interrupt.

## Interface
- DEPTH, 1024, number of 32-bit words in the memory
- ADDR_WIDTH, 10, index width; must equal clog2(DEPTH)

- clk  input  1  rising-edge clock for all logic
- rst  input  1  synchronous, active-low reset; rst = 0 sampled on a rising edge resets the block
- i_wbs_we  input  1  1 = write cycle, 0 = read cycle
- i_wbs_stb  input  1  strobe
- i_wbs_cyc  input  1  bus cycle valid
- i_wbs_sel  input  4  byte-lane enables; bit n selects data bits [8n+7:8n]
- i_wbs_adr  input  32  word address
- i_wbs_dat  input  32  write data
- o_wbs_dat  output  32  read data, registered
- o_wbs_ack  output  1  cycle acknowledge, registered
- o_wbs_int  output  1  sticky out-of-range interrupt, registered

## Operation
- Request: i_wbs_stb & i_wbs_cyc both high, sampled on a rising edge in IDLE.
- In range: i_wbs_adr < DEPTH, using a full 32-bit compare. Memory index is i_wbs_adr[ADDR_WIDTH-1:0].
- States:
  - IDLE: no ack.
  - RD_WAIT: RAM read issued.
  - ACK: o_wbs_ack = 1, held while the request persists.
- Transitions:
  - IDLE → ACK: write request.
  - IDLE → RD_WAIT: read request.
  - RD_WAIT → ACK: always, unless cyc is low (then → IDLE, no ack).
  - ACK → IDLE: on the first edge where stb or cyc is low.
- Write, in range: on the sampling edge, each byte lane with sel bit = 1 is updated; lanes with sel = 0 keep their value. sel = 4'h0 completes with ack and changes nothing.
- Write, out of range: memory unchanged; ack still given; o_wbs_int set.
- Read, in range: o_wbs_dat is loaded with the full 32-bit word on the RD_WAIT → ACK edge. sel is ignored for reads.
- Read, out of range: o_wbs_dat loaded with 32'h0; o_wbs_int set.
- o_wbs_dat holds its value until the next read completes; writes do not alter it.
- o_wbs_int:
  - Set on any out-of-range access.
  - Cleared by the next in-range write.
  - If set and clear land on the same edge, set wins (impossible in practice: one access per cycle).
- Request inputs are sampled only in IDLE. Changes to we/adr/dat/sel during RD_WAIT or ACK are ignored.

## Timing
- Reset values: o_wbs_dat = 32'h0, o_wbs_ack = 0, o_wbs_int = 0, state = IDLE. Memory contents are not cleared by reset.
- Reset mid-cycle (any state): the outputs above are forced on that edge. A write already committed stays; a pending read is dropped.
- Write: request sampled at edge N → RAM updated and o_wbs_ack = 1 after edge N (1-cycle latency).
- Read: request sampled at edge N → o_wbs_dat valid and o_wbs_ack = 1 after edge N+1 (2-cycle latency).
- Ack release: stb/cyc low sampled at edge M → o_wbs_ack = 0 after edge M.
- Minimum spacing: one IDLE cycle is guaranteed between cycles. The earliest next request is sampled at edge M+1.
- Back-to-back: no pipelined (stb held across ack) transfers. Stb held high after ack keeps ack high, and no second transfer occurs.

## Test plan
- Reset: drive rst = 0 for 2 cycles with stb/cyc = 1 → ack = 0, dat = 0, int = 0 throughout; no memory write.
- Byte-lane write: write 32'hAABBCCDD to adr 5 with sel 4'hF, then 32'h11223344 with sel 4'b0101; read adr 5 → 32'hAA22CC44. Write ack arrives 1 cycle after strobe; read ack arrives 2 cycles after strobe.
- Ack hold: hold stb for 4 cycles during a read → ack high for 3 cycles and drops the cycle after stb falls; a second request one cycle later is served normally.
- Out of range: write to adr DEPTH → ack, int = 1, adr 0 unchanged. Read adr 32'hFFFF_FFFF → dat = 0, int stays 1. In-range write → int = 0.
- Abort: raise stb/cyc for a read, drop cyc while in RD_WAIT → no ack, o_wbs_dat keeps its previous value, next cycle is served.
- Boundary: write/read adr DEPTH-1 with 32'hDEADBEEF → reads back exactly; int stays 0.
